// File: rtl/proc_host_ctrl.sv
// Host-side run initiator: preloads data memory, pulses req, waits for done (with timeout), streams results out.
// src_valid / res_ready stalls freeze the word index and address; start is ignored while busy.
module proc_host_ctrl #(
  parameter int AW  = 8,
  parameter int TMO = 4095
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] ld_base,
  input  logic [7:0]    ld_count,
  input  logic [AW-1:0] rd_base,
  input  logic [7:0]    rd_count,
  input  logic          src_valid,
  input  logic [7:0]    src_data,
  output logic          src_ready,
  output logic          dm_wr_en,
  output logic [AW-1:0] dm_addr,
  output logic [7:0]    dm_wdata,
  input  logic [7:0]    dm_rdata,
  output logic          req,
  input  logic          done_in,
  output logic          res_valid,
  output logic [7:0]    res_data,
  input  logic          res_ready,
  output logic          busy,
  output logic          fin,
  output logic          timeout,
  output logic [15:0]   cycles
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_REQ,
    S_WAIT,
    S_READ,
    S_FIN
  } state_t;

  localparam logic [15:0] TMO_C = 16'(TMO);

  state_t        state;
  logic [AW-1:0] ld_base_q;
  logic [AW-1:0] rd_base_q;
  logic [7:0]    ld_cnt_q;
  logic [7:0]    rd_cnt_q;
  logic [7:0]    idx;
  logic [15:0]   cyc_nxt;

  // Timeout compares against the post-increment count so WAIT lasts exactly TMO cycles.
  assign cyc_nxt = (cycles == 16'hFFFF) ? cycles : cycles + 16'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      ld_base_q <= '0;
      rd_base_q <= '0;
      ld_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      idx       <= '0;
      cycles    <= '0;
      timeout   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            ld_base_q <= ld_base;
            rd_base_q <= rd_base;
            ld_cnt_q  <= ld_count;
            rd_cnt_q  <= rd_count;
            idx       <= '0;
            cycles    <= '0;
            timeout   <= 1'b0;
            state     <= (ld_count != 8'd0) ? S_LOAD : S_REQ;
          end
        end
        S_LOAD: begin
          if (src_valid) begin
            if (idx == ld_cnt_q - 8'd1) begin
              idx   <= '0;
              state <= S_REQ;
            end else begin
              idx <= idx + 8'd1;
            end
          end
        end
        S_REQ: state <= S_WAIT;
        S_WAIT: begin
          cycles <= cyc_nxt;
          if (done_in) begin
            state <= (rd_cnt_q != 8'd0) ? S_READ : S_FIN;
          end else if (cyc_nxt == TMO_C) begin
            timeout <= 1'b1;
            state   <= S_FIN;
          end
        end
        S_READ: begin
          if (res_ready) begin
            if (idx == rd_cnt_q - 8'd1) begin
              idx   <= '0;
              state <= S_FIN;
            end else begin
              idx <= idx + 8'd1;
            end
          end
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (state != S_IDLE);
  assign src_ready = (state == S_LOAD);
  assign req       = (state == S_REQ);
  assign fin       = (state == S_FIN);
  assign res_valid = (state == S_READ);
  assign dm_wr_en  = (state == S_LOAD) && src_valid;
  assign dm_wdata  = (state == S_LOAD) ? src_data : 8'd0;
  assign res_data  = (state == S_READ) ? dm_rdata : 8'd0;

  // Address wraps modulo 2^AW; outside LOAD/READ it is parked at zero.
  always_comb begin
    dm_addr = '0;
    if (state == S_LOAD) begin
      dm_addr = ld_base_q + AW'(idx);
    end else if (state == S_READ) begin
      dm_addr = rd_base_q + AW'(idx);
    end
  end

endmodule

// File: tb/tb_proc_host_ctrl.sv
// Scoreboard bench for proc_host_ctrl: expected writes, result beats and run summaries are queued per run.
module tb_proc_host_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  ld_base = 8'd0;
  logic [7:0]  ld_count = 8'd0;
  logic [7:0]  rd_base = 8'd0;
  logic [7:0]  rd_count = 8'd0;
  logic        src_valid = 1'b0;
  logic [7:0]  src_data = 8'd0;
  logic        src_ready;
  logic        dm_wr_en;
  logic [7:0]  dm_addr;
  logic [7:0]  dm_wdata;
  logic [7:0]  dm_rdata;
  logic        req;
  logic        done_in = 1'b0;
  logic        res_valid;
  logic [7:0]  res_data;
  logic        res_ready = 1'b0;
  logic        busy;
  logic        fin;
  logic        timeout;
  logic [15:0] cycles;

  always #5 clk = ~clk;

  proc_host_ctrl #(.AW(8), .TMO(20)) dut (
    .clk(clk), .reset(reset), .start(start),
    .ld_base(ld_base), .ld_count(ld_count), .rd_base(rd_base), .rd_count(rd_count),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .dm_wr_en(dm_wr_en), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
    .req(req), .done_in(done_in),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .busy(busy), .fin(fin), .timeout(timeout), .cycles(cycles)
  );

  // Data memory model: combinational read, write sampled mid-cycle.
  logic [7:0] mem [256];
  assign dm_rdata = mem[dm_addr];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'd0;
    mem[8'h40] = 8'hA0;
    mem[8'h41] = 8'hA1;
    forever begin
      @(negedge clk);
      if (dm_wr_en) mem[dm_addr] = dm_wdata;
    end
  end

  int n_pass = 0;
  int n_tot  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    int kind;
    int a;
    int d;
  } ev_t;
  ev_t q[$];

  task automatic push(input int k, input int a, input int d);
    ev_t e;
    e.kind = k;
    e.a = a;
    e.d = d;
    q.push_back(e);
  endtask

  task automatic expect_ev(input int k, input int a, input int d, input string name);
    ev_t e;
    if (q.size() == 0) begin
      n_tot++;
      $display("FAIL %s: unexpected event a=0x%0h d=0x%0h, none expected", name, a, d);
    end else begin
      e = q.pop_front();
      check({name, "_kind"}, k, e.kind);
      if (k != 1) check({name, "_a"}, a, e.a);
      check({name, "_d"}, d, e.d);
    end
  endtask

  // Monitor: kind 0 = memory write, 1 = result beat, 2 = run summary at fin.
  always @(negedge clk) begin
    if (reset) begin
      if (dm_wr_en) expect_ev(0, int'(dm_addr), int'(dm_wdata), "wr");
      if (res_valid && res_ready) expect_ev(1, 0, int'(res_data), "rd");
      if (fin) expect_ev(2, int'(cycles), int'(timeout), "fin");
    end
  end

  logic [7:0] ldat [4];
  logic [7:0] rexp [4];

  task automatic chk_reset_outs();
    check("rst_src_ready", src_ready, 0);
    check("rst_dm_wr_en", dm_wr_en, 0);
    check("rst_req", req, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_fin", fin, 0);
    check("rst_timeout", timeout, 0);
    check("rst_cycles", cycles, 0);
    check("rst_dm_addr", dm_addr, 0);
    check("rst_dm_wdata", dm_wdata, 0);
    check("rst_res_data", res_data, 0);
  endtask

  task automatic do_start(input logic [7:0] lb, input int lc, input logic [7:0] rb, input int rc);
    ld_base = lb;
    ld_count = 8'(lc);
    rd_base = rb;
    rd_count = 8'(rc);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    #1;
    check("start_busy", busy, 1);
    check("start_timeout_clr", timeout, 0);
    check("start_cycles_clr", cycles, 0);
  endtask

  task automatic run_load(input logic [7:0] lb, input int n, input bit sl);
    int i = 0;
    int t = 0;
    logic v;
    logic [7:0] ea;
    while (i < n && t < 64) begin
      v = sl ? (t % 2 == 0) : 1'b1;
      src_valid = v;
      src_data = ldat[i];
      @(negedge clk);
      ea = lb + 8'(i);
      check("ld_src_ready", src_ready, 1);
      check("ld_addr", dm_addr, ea);
      @(posedge clk);
      #1;
      if (v) i++;
      t++;
    end
    src_valid = 1'b0;
    src_data = 8'd0;
    check("ld_cycles", t, sl ? 2 * n - 1 : n);
  endtask

  task automatic wait_done(input int k);
    for (int c = 1; c <= k; c++) begin
      @(negedge clk);
      if (c == 1) check("req_single", req, 0);
    end
    done_in = 1'b1;
    @(posedge clk);
    #1 done_in = 1'b0;
  endtask

  task automatic run_read(input logic [7:0] rb, input int n, input bit sr);
    int j = 0;
    int t = 0;
    logic r;
    logic [7:0] ea;
    while (j < n && t < 64) begin
      r = sr ? !(t >= 1 && t <= 3) : 1'b1;
      res_ready = r;
      @(negedge clk);
      ea = rb + 8'(j);
      check("rd_valid", res_valid, 1);
      check("rd_addr", dm_addr, ea);
      @(posedge clk);
      #1;
      if (r) j++;
      t++;
    end
    res_ready = 1'b0;
    check("rd_cycles", t, sr ? n + 3 : n);
  endtask

  task automatic wait_idle();
    int w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (busy && w < 40);
    check("return_idle", busy, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [7:0] lb, input int lc, input logic [7:0] rb, input int rc,
                     input bit sl, input bit sr, input int k);
    logic [7:0] a;
    for (int i = 0; i < lc; i++) begin
      a = lb + 8'(i);
      push(0, int'(a), int'(ldat[i]));
    end
    for (int j = 0; j < rc; j++) push(1, 0, int'(rexp[j]));
    push(2, k, 0);
    do_start(lb, lc, rb, rc);
    if (lc > 0) run_load(lb, lc, sl);
    @(negedge clk);
    check("req_pulse", req, 1);
    wait_done(k);
    if (rc > 0) run_read(rb, rc, sr);
    wait_idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, pending=%0d", q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk_reset_outs();
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Basic run: 4 loads at 0x01, done after 10 WAIT cycles, 2 reads at 0x40.
    ldat[0] = 8'h11; ldat[1] = 8'h22; ldat[2] = 8'h33; ldat[3] = 8'h44;
    rexp[0] = 8'hA0; rexp[1] = 8'hA1;
    run(8'h01, 4, 8'h40, 2, 1'b0, 1'b0, 10);

    // Same run with source and result stalls.
    run(8'h01, 4, 8'h40, 2, 1'b1, 1'b1, 10);

    // Timeout with a stray start during WAIT.
    push(2, 20, 1);
    done_in = 1'b0;
    do_start(8'h10, 0, 8'h40, 2);
    @(negedge clk);
    check("tmo_req", req, 1);
    @(posedge clk);
    #1 ld_count = 8'd1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);
    check("start_ignored", busy, 0);
    @(posedge clk);
    #1;

    // Zero counts with done already high: REQ, WAIT, FIN, IDLE.
    push(2, 1, 0);
    done_in = 1'b1;
    do_start(8'h00, 0, 8'h00, 0);
    @(negedge clk);
    check("zc_req", req, 1);
    @(negedge clk);
    check("zc_wait_req", req, 0);
    check("zc_wait_busy", busy, 1);
    @(negedge clk);
    check("zc_fin", fin, 1);
    @(negedge clk);
    check("zc_idle", busy, 0);
    done_in = 1'b0;
    @(posedge clk);
    #1;

    // Address wrap: load 0xFE..0x01, read back 0xFF and 0x00.
    ldat[0] = 8'h5A; ldat[1] = 8'h5B; ldat[2] = 8'h5C; ldat[3] = 8'h5D;
    rexp[0] = 8'h5B; rexp[1] = 8'h5C;
    run(8'hFE, 4, 8'hFF, 2, 1'b0, 1'b0, 3);

    // Reset mid-LOAD after two words, then a fresh run reading the partial load.
    ldat[0] = 8'h11; ldat[1] = 8'h22;
    push(0, 8'h80, 8'h11);
    push(0, 8'h81, 8'h22);
    do_start(8'h80, 4, 8'h40, 2);
    run_load(8'h80, 2, 1'b0);
    src_valid = 1'b1;
    src_data = 8'h99;
    #1 reset = 1'b0;
    #1 chk_reset_outs();
    src_valid = 1'b0;
    src_data = 8'd0;
    @(posedge clk);
    #1 reset = 1'b1;
    ldat[0] = 8'h66; ldat[1] = 8'h77;
    rexp[0] = 8'h11; rexp[1] = 8'h22;
    run(8'h10, 2, 8'h80, 2, 1'b0, 1'b0, 5);

    repeat (2) @(negedge clk);
    check("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/proc_host_ctrl.md
# proc_host_ctrl

Host-side initiator for the processor's `req`/`done` run handshake. It preloads operands into the processor data memory through a streaming source port and pulses `req` to launch a run. It then waits for `done` with a cycle count and timeout, and streams result words back out of data memory. It sits between the bench or system host and one processor core, owning the core's data-memory write/read port while the core is idle.

## Interface
Parameters:
- `AW`, 8: data-memory address width; addresses wrap modulo 2^AW.
- `TMO`, 4095: maximum cycles waited for `done` before declaring timeout.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: launch request; sampled only in IDLE.
- `ld_base` in AW: first data-memory address to load; captured at start.
- `ld_count` in 8: number of words to load; captured at start.
- `rd_base` in AW: first data-memory address to read back; captured at start.
- `rd_count` in 8: number of words to read back; captured at start.
- `src_valid` in 1: source word available.
- `src_data` in 8: source word.
- `src_ready` out 1: high in LOAD.
- `dm_wr_en` out 1: data-memory write strobe.
- `dm_addr` out AW: data-memory address.
- `dm_wdata` out 8: data-memory write data.
- `dm_rdata` in 8: data-memory read data. The read is combinational, so data is valid in the same cycle as `dm_addr`.
- `req` out 1: run launch to the processor.
- `done_in` in 1: processor done level.
- `res_valid` out 1: result word valid.
- `res_data` out 8: result word.
- `res_ready` in 1: result consumer ready.
- `busy` out 1: high in any state other than IDLE.
- `fin` out 1: one-cycle pulse on return to IDLE.
- `timeout` out 1: sticky flag for the last run; cleared at the next accepted start.
- `cycles` out 16: WAIT-cycle count of the last run; saturates at 0xFFFF.

## Operation
- States are IDLE, LOAD, REQ, WAIT, READ, FIN.
- IDLE:
  - If `start` is high, capture base and count inputs, clear `cycles`, `timeout`, and the word index.
  - Go to LOAD if `ld_count` is nonzero, else go to REQ.
- LOAD:
  - `src_ready` is 1. `dm_addr` = `ld_base` + idx; `dm_wdata` = `src_data`; `dm_wr_en` = `src_valid` (combinational).
  - Each cycle with `src_valid` high increments idx.
  - When the accepted word is word `ld_count`-1, reset idx and go to REQ.
- REQ: `req` = 1 for exactly this one cycle, then go to WAIT.
- WAIT:
  - Each cycle, `cycles` increments, saturating.
  - If `done_in` is high, go to READ if `rd_count` is nonzero, else go to FIN.
  - Otherwise, if `cycles` equals TMO, set `timeout` and go to FIN, skipping readback.
- READ:
  - `dm_addr` = `rd_base` + idx; `res_data` = `dm_rdata`; `res_valid` = 1.
  - Each cycle with `res_ready` high increments idx.
  - After the handshake on word `rd_count`-1, go to FIN.
- FIN: `fin` = 1 for one cycle, then go to IDLE.
- Address arithmetic is AW bits and wraps; for example, base 0xFE with count 4 touches 0xFE, 0xFF, 0x00, 0x01.
- `start` outside IDLE is ignored; no queuing.
- `done_in` is not sampled outside WAIT. A `done_in` already high on the first WAIT cycle ends WAIT immediately, with `cycles` = 1.
- Reset asserted mid-operation forces IDLE immediately:
  - All counters and flags clear.
  - A partially loaded memory is left as-is.

## Timing
- Reset values:
  - `src_ready`, `dm_wr_en`, `req`, `res_valid`, `busy`, `fin`, `timeout` = 0.
  - `cycles` = 0, `dm_addr` = 0, `dm_wdata` = 0, `res_data` = 0.
- `dm_addr`, `dm_wdata`, and `res_data` are driven 0 in IDLE, REQ, WAIT, and FIN.
- `start` seen at edge N: `busy` goes high from N+1.
  - With nonzero counts, LOAD begins at N+1.
  - With both counts zero and `done_in` already high: REQ at N+1, WAIT at N+2, FIN at N+3, IDLE at N+4.
- LOAD takes exactly `ld_count` cycles when `src_valid` is held high.
- READ takes exactly `rd_count` cycles when `res_ready` is held high.
- Stalls on `src_valid` or `res_ready` hold idx and `dm_addr` stable.
- Timeout: WAIT lasts exactly TMO cycles, and `cycles` = TMO at FIN.

## Test plan
- Load 4 words {0x11,0x22,0x33,0x44} at base 0x01 with `src_valid` held high; `done_in` rises 10 cycles after `req`; read back 2 words at 0x40 -> 4 writes to 0x01..0x04 on consecutive cycles, single-cycle `req`, `cycles` = 10, 2 result beats, `fin` pulse, `timeout` = 0.
- Same run with `src_valid` toggling 1,0,1,0 and `res_ready` low for 3 cycles mid-read -> no writes or result advances during stalls; `dm_addr` holds; totals unchanged.
- `done_in` tied low, TMO = 20 -> `timeout` = 1, `cycles` = 20, no READ beats, `fin` pulses. The next `start` clears `timeout`.
- `ld_count` = 0, `rd_count` = 0, `done_in` high -> REQ → WAIT → FIN → IDLE with `cycles` = 1 and no `dm_wr_en` at any time.
- Base 0xFE with `ld_count` 4 -> writes to 0xFE, 0xFF, 0x00, 0x01 (wrap).
- `start` pulsed during WAIT; reset pulsed low mid-LOAD -> the extra `start` is ignored. Reset returns all outputs to reset values asynchronously, and a fresh `start` then runs normally.
